cla_adder_bist: RTL and testbench
=================================

// Module: cla_adder_bist
// PURPOSE
//  Built-in self-test engine for the 4-bit carry-look-ahead adder.
//  Generates pseudo-random {a, b, c_in} vectors from an on-chip LFSR and drives
//  them into the adder under test. Checks {c_out, sum} against a + b + c_in and
//  reports pass/fail, an error count and the first failing vector.
//  Sits beside the adder instance and is controlled by a start pulse from system control.
// PARAMETERS
//  WIDTH        4       operand width; vector width VW = 2*WIDTH+1
//  NUM_VECTORS  30      vectors per run (1..65535)
//  HOLD         1       cycles each vector is held before compare (1..15)
//  SEED         9'h1A5  LFSR load value (VW bits); 0 is replaced by 1
//  LFSR_POLY    9'h110  Galois right-shift feedback mask (x^9+x^5+1)
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      1-cycle request to begin a run
//  a           out  WIDTH  operand A to DUT (registered)
//  b           out  WIDTH  operand B to DUT (registered)
//  c_in        out  1      carry-in to DUT (registered)
//  sum         in   WIDTH  DUT sum (combinational DUT, valid same cycle)
//  c_out       in   1      DUT carry-out
//  busy        out  1      run in progress
//  done        out  1      run finished, results valid (level)
//  pass        out  1      done & err_cnt==0
//  err_cnt     out  8      mismatch count, saturates at 8'hFF
//  fail_valid  out  1      at least one mismatch captured this run
//  fail_vec    out  VW     {a,b,c_in} of first mismatch
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, a/b/c_in=0, busy/done/pass=0, err_cnt=0,
//   fail_valid=0, fail_vec=0, lfsr=0, vec_cnt=0, hold_cnt=0.
//  FSM IDLE -> RUN -> DONE.
//   IDLE: start=1 -> RUN. Load lfsr=SEED; drive {a,b,c_in}=SEED; clear err_cnt,
//    fail_valid, fail_vec, vec_cnt and hold_cnt; done=0; busy=1 next cycle.
//   RUN: vector {a,b,c_in}=lfsr[VW-1:0] (a=MSBs, c_in=LSB), held HOLD cycles.
//    Compare on the last hold cycle, at that clock edge:
//    mismatch if {c_out,sum} != a+b+c_in (WIDTH+1-bit, no truncation).
//    On mismatch: err_cnt+1 (saturating at 255); if !fail_valid, capture
//    fail_vec={a,b,c_in} and set fail_valid.
//    Same edge: lfsr <= lfsr[0] ? (lfsr>>1)^LFSR_POLY : lfsr>>1; drive new
//    lfsr; vec_cnt+1. After compare of vector NUM_VECTORS-1 -> DONE.
//    start is ignored in RUN.
//   DONE: busy=0, done=1, pass=(err_cnt==0); a/b/c_in keep the last driven
//    value. start=1 restarts exactly as from IDLE (done drops the next cycle).
//  Latency: busy rises 1 cycle after start; done rises NUM_VECTORS*HOLD cycles
//   after busy rises; busy and done are never both 1.
//  LFSR wraps with period 2^VW-1. NUM_VECTORS above the period repeats vectors
//   (legal).
//  rst_n low mid-run aborts immediately to reset values; no partial results
//   are retained.
// TESTING
//  T1 golden adder model, defaults, start pulse -> cycle after start
//   a=4'hD,b=4'h2,c_in=1; next a=4'hE,b=4'h1,c_in=0; done 30 cycles after busy; pass=1, err_cnt=0.
//  T2 DUT sum[0] stuck-at-0 -> vector 1 (sum=0) passes; vector 2 fails:
//   fail_vec=9'h1C2, fail_valid=1, pass=0, err_cnt>=1.
//  T3 DUT always returns inverted {c_out,sum}, NUM_VECTORS=300 -> err_cnt=8'hFF (saturated), pass=0.
//  T4 HOLD=3, golden DUT -> each vector stable 3 cycles; done 90 cycles after busy; pass=1.
//  T5 start re-pulsed mid-RUN -> ignored, run length unchanged; start in DONE -> counters cleared, SEED vector re-driven.
//  T6 rst_n low at vector 10 -> all outputs 0 asynchronously; fresh start gives T1 result.

Source files
------------

// File: rtl/cla_adder_bist.sv
// Self-test engine for a combinational WIDTH-bit adder: LFSR-driven {a,b,c_in}
// vectors, compare of {c_out,sum} against a+b+c_in, error count and first-failure capture.
module cla_adder_bist #(
  parameter int                 WIDTH       = 4,
  parameter int                 NUM_VECTORS = 30,
  parameter int                 HOLD        = 1,
  parameter logic [2*WIDTH:0]   SEED        = 9'h1A5,
  parameter logic [2*WIDTH:0]   LFSR_POLY   = 9'h110
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               c_in,
  input  logic [WIDTH-1:0]   sum,
  input  logic               c_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_cnt,
  output logic               fail_valid,
  output logic [2*WIDTH:0]   fail_vec
);

  localparam int               VW       = 2*WIDTH + 1;
  localparam logic [VW-1:0]    SEED_EFF = (SEED == '0) ? VW'(1) : SEED;
  localparam logic [15:0]      NV_M1    = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]       HOLD_M1  = 4'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [VW-1:0]   lfsr;
  logic [15:0]     vec_cnt;
  logic [3:0]      hold_cnt;

  logic [WIDTH:0]  expected;
  logic            mismatch;
  logic            last_hold;
  logic            last_vec;
  logic [VW-1:0]   lfsr_next;
  logic [7:0]      err_next;

  always_comb begin
    expected  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    mismatch  = ({c_out, sum} != expected);
    last_hold = (hold_cnt == HOLD_M1);
    last_vec  = (vec_cnt == NV_M1);
    lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
    err_next  = (mismatch && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      c_in       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      lfsr       <= '0;
      vec_cnt    <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            lfsr         <= SEED_EFF;
            {a, b, c_in} <= SEED_EFF;
            err_cnt      <= '0;
            fail_valid   <= 1'b0;
            fail_vec     <= '0;
            vec_cnt      <= '0;
            hold_cnt     <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
          end
        end
        RUN: begin
          if (last_hold) begin
            hold_cnt <= '0;
            err_cnt  <= err_next;
            if (mismatch && !fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= {a, b, c_in};
            end
            // The final vector stays on the bus so DONE shows what was last tested.
            if (last_vec) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 8'd0);
            end else begin
              lfsr         <= lfsr_next;
              {a, b, c_in} <= lfsr_next;
              vec_cnt      <= vec_cnt + 16'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_adder_bist.sv
// Bench for cla_adder_bist: three instances (defaults, 300 vectors, HOLD=3) driving a
// behavioural adder with selectable faults; expected vectors come from a bench-side LFSR.
module tb_cla_adder_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s [3];
  logic [3:0] a_s     [3];
  logic [3:0] b_s     [3];
  logic [3:0] sum_s   [3];
  logic       c_in_s  [3];
  logic       c_out_s [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       pass_s  [3];
  logic       fv_s    [3];
  logic [7:0] err_s   [3];
  logic [8:0] fvec_s  [3];
  int         mode_s  [3];

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q [$];

  // mode 0: correct adder, 1: sum[0] stuck at 0, 2: whole result inverted
  function automatic logic [4:0] adder_model(input int mode, input logic [3:0] x,
                                             input logic [3:0] y, input logic ci);
    logic [4:0] r;
    r = 5'(x) + 5'(y) + 5'(ci);
    if (mode == 1) r[0] = 1'b0;
    if (mode == 2) r = ~r;
    return r;
  endfunction

  function automatic logic [8:0] lfsr_step(input logic [8:0] l);
    logic fb;
    fb = l[0];
    l  = {1'b0, l[8:1]};
    if (fb) l = l ^ 9'h110;
    return l;
  endfunction

  assign {c_out_s[0], sum_s[0]} = adder_model(mode_s[0], a_s[0], b_s[0], c_in_s[0]);
  assign {c_out_s[1], sum_s[1]} = adder_model(mode_s[1], a_s[1], b_s[1], c_in_s[1]);
  assign {c_out_s[2], sum_s[2]} = adder_model(mode_s[2], a_s[2], b_s[2], c_in_s[2]);

  cla_adder_bist u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]), .c_in(c_in_s[0]),
    .sum(sum_s[0]), .c_out(c_out_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_cnt(err_s[0]), .fail_valid(fv_s[0]), .fail_vec(fvec_s[0]));

  cla_adder_bist #(.NUM_VECTORS(300)) u_long (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]), .c_in(c_in_s[1]),
    .sum(sum_s[1]), .c_out(c_out_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_cnt(err_s[1]), .fail_valid(fv_s[1]), .fail_vec(fvec_s[1]));

  cla_adder_bist #(.HOLD(3)) u_hold (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]), .c_in(c_in_s[2]),
    .sum(sum_s[2]), .c_out(c_out_s[2]), .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
    .err_cnt(err_s[2]), .fail_valid(fv_s[2]), .fail_vec(fvec_s[2]));

  task automatic run_and_check(input int sel, input int n, input int h, input int mode,
                               input int restart_at, input string tag);
    logic [8:0] l, v, got, fv_exp;
    logic [4:0] truth, model_out;
    int         errs;
    bit         fv_seen;
    logic [7:0] err_exp;
    mode_s[sel] = mode;
    l = 9'h1A5;
    errs = 0;
    fv_seen = 1'b0;
    fv_exp = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(l);
      truth     = adder_model(0, l[8:5], l[4:1], l[0]);
      model_out = adder_model(mode, l[8:5], l[4:1], l[0]);
      if (model_out != truth) begin
        errs++;
        if (!fv_seen) begin
          fv_seen = 1'b1;
          fv_exp  = l;
        end
      end
      l = lfsr_step(l);
    end
    err_exp = (errs > 255) ? 8'hFF : 8'(errs);

    @(negedge clk) start_s[sel] = 1'b1;
    @(negedge clk) start_s[sel] = 1'b0;
    tests++;
    if (err_s[sel] !== 8'd0 || fv_s[sel] !== 1'b0 || done_s[sel] !== 1'b0 || busy_s[sel] !== 1'b1) begin
      fails++;
      $display("FAIL %s start_state: err=%h fv=%b done=%b busy=%b, want err=00 fv=0 done=0 busy=1",
               tag, err_s[sel], fv_s[sel], done_s[sel], busy_s[sel]);
    end

    for (int i = 0; i < n; i++) begin
      v = exp_q.pop_front();
      for (int k = 0; k < h; k++) begin
        got = {a_s[sel], b_s[sel], c_in_s[sel]};
        tests++;
        if (got !== v || busy_s[sel] !== 1'b1 || done_s[sel] !== 1'b0) begin
          fails++;
          $display("FAIL %s vec%0d.%0d: got vec=%h busy=%b done=%b, want vec=%h busy=1 done=0",
                   tag, i, k, got, busy_s[sel], done_s[sel], v);
        end
        start_s[sel] = (i == restart_at && k == 0);
        @(negedge clk);
      end
    end
    start_s[sel] = 1'b0;

    tests++;
    if (done_s[sel] !== 1'b1 || busy_s[sel] !== 1'b0 || pass_s[sel] !== (errs == 0) ||
        err_s[sel] !== err_exp || fv_s[sel] !== fv_seen || fvec_s[sel] !== fv_exp) begin
      fails++;
      $display("FAIL %s result: got done=%b busy=%b pass=%b err=%h fv=%b fvec=%h, want done=1 busy=0 pass=%b err=%h fv=%b fvec=%h",
               tag, done_s[sel], busy_s[sel], pass_s[sel], err_s[sel], fv_s[sel], fvec_s[sel],
               (errs == 0), err_exp, fv_seen, fv_exp);
    end
  endtask

  task automatic check_zero(input int sel, input string tag);
    tests++;
    if ({a_s[sel], b_s[sel], c_in_s[sel]} !== 9'd0 || busy_s[sel] !== 1'b0 || done_s[sel] !== 1'b0 ||
        pass_s[sel] !== 1'b0 || err_s[sel] !== 8'd0 || fv_s[sel] !== 1'b0 || fvec_s[sel] !== 9'd0) begin
      fails++;
      $display("FAIL %s: got vec=%h busy=%b done=%b pass=%b err=%h fv=%b fvec=%h, want all zero",
               tag, {a_s[sel], b_s[sel], c_in_s[sel]}, busy_s[sel], done_s[sel], pass_s[sel],
               err_s[sel], fv_s[sel], fvec_s[sel]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(0, "reset_dut");
    check_zero(1, "reset_long");
    check_zero(2, "reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_golden();
    run_and_check(0, 30, 1, 0, -1, "golden");
  endtask

  task automatic test_stuck_sum();
    run_and_check(0, 30, 1, 1, -1, "stuck");
    tests++;
    if (fvec_s[0] !== 9'h1C2 || err_s[0] === 8'd0) begin
      fails++;
      $display("FAIL stuck_first: got fvec=%h err=%h, want fvec=1c2 err>=1", fvec_s[0], err_s[0]);
    end
  endtask

  task automatic test_restart_from_done();
    run_and_check(0, 30, 1, 1, -1, "restart_done");
  endtask

  task automatic test_saturate();
    run_and_check(1, 300, 1, 2, -1, "saturate");
    tests++;
    if (err_s[1] !== 8'hFF) begin
      fails++;
      $display("FAIL saturate_cnt: got err=%h, want ff", err_s[1]);
    end
  endtask

  task automatic test_hold3();
    run_and_check(2, 30, 3, 0, -1, "hold3");
  endtask

  task automatic test_start_mid_run();
    run_and_check(0, 30, 1, 0, 12, "mid_start");
  endtask

  task automatic test_abort();
    mode_s[0] = 0;
    @(negedge clk) start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(0, "abort_async");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_and_check(0, 30, 1, 0, -1, "after_abort");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      mode_s[i]  = 0;
    end
    rst_n = 1'b0;
    test_reset();
    test_golden();
    test_stuck_sum();
    test_restart_from_done();
    test_saturate();
    test_hold3();
    test_start_mid_run();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
